// File: rtl/count_seg_display.sv
// Wrap detector and BCD wrap counter for a 4-bit down counter, driving a
// 4-digit multiplexed 7-segment display (digit 0 = live count, 2/3 = wraps).
module count_seg_display #(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_in,
    input  logic       wrap_clr,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [7:0] wrap_cnt,
    output logic       wrap_pulse
);

    localparam int unsigned        PRESC_W    = 16;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [6:0]         SEG_BLANK  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic [1:0] {
        DIG_CNT   = 2'd0,
        DIG_BLANK = 2'd1,
        DIG_ONES  = 2'd2,
        DIG_TENS  = 2'd3
    } digit_t;

    digit_t             idx;
    digit_t             idx_next;
    logic [3:0]         cnt_prev;
    logic               prev_vld;
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_next;
    logic               wrap_det;
    logic [7:0]         wrap_inc;
    logic [6:0]         glyph;
    logic [6:0]         seg_next;
    logic [3:0]         an_next;

    // Standard hex glyphs, active-high {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // prev_vld masks the first sample after reset so a stale cnt_prev cannot fake a wrap
    assign wrap_det = prev_vld && (cnt_prev == 4'h0) && (cnt_in == 4'hF);

    // Two-digit BCD increment, 99 rolls to 00
    always_comb begin
        wrap_inc = wrap_cnt;
        if (wrap_cnt[3:0] == 4'd9) begin
            wrap_inc[3:0] = 4'd0;
            wrap_inc[7:4] = (wrap_cnt[7:4] == 4'd9) ? 4'd0 : wrap_cnt[7:4] + 4'd1;
        end else begin
            wrap_inc[3:0] = wrap_cnt[3:0] + 4'd1;
        end
    end

    // Scan next-state and next display outputs
    always_comb begin
        presc_next = presc + PRESC_W'(1);
        idx_next   = idx;
        an_next    = 4'hF;
        glyph      = 7'h00;

        if (presc == PRESC_LAST) begin
            presc_next = '0;
            case (idx)
                DIG_CNT:   idx_next = DIG_BLANK;
                DIG_BLANK: idx_next = DIG_ONES;
                DIG_ONES:  idx_next = DIG_TENS;
                default:   idx_next = DIG_CNT;
            endcase
        end

        case (idx)
            DIG_CNT: begin
                an_next = 4'b1110;
                glyph   = hex_glyph(cnt_prev);
            end
            DIG_BLANK: begin
                an_next = 4'b1101;
                glyph   = 7'h00;
            end
            DIG_ONES: begin
                an_next = 4'b1011;
                glyph   = hex_glyph(wrap_cnt[3:0]);
            end
            default: begin
                an_next = 4'b0111;
                glyph   = hex_glyph(wrap_cnt[7:4]);
            end
        endcase

        seg_next = SEG_ACTIVE_LOW ? ~glyph : glyph;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_prev   <= 4'h0;
            prev_vld   <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= 8'h00;
            presc      <= '0;
            idx        <= DIG_CNT;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
        end else begin
            cnt_prev   <= cnt_in;
            prev_vld   <= 1'b1;
            wrap_pulse <= wrap_det;
            if (wrap_clr) begin
                wrap_cnt <= 8'h00;
            end else if (wrap_det) begin
                wrap_cnt <= wrap_inc;
            end
            presc      <= presc_next;
            idx        <= idx_next;
            an         <= an_next;
            seg        <= seg_next;
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// Directed self-checking bench for count_seg_display (REFRESH_DIV=4, active-low segments).
module tb_count_seg_display;

    logic       clk;
    logic       rst;
    logic [3:0] cnt_in;
    logic       wrap_clr;
    logic [6:0] seg;
    logic [3:0] an;
    logic [7:0] wrap_cnt;
    logic       wrap_pulse;

    int checks;
    int errors;
    int ecount;
    int nwraps;

    count_seg_display #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_in    (cnt_in),
        .wrap_clr  (wrap_clr),
        .seg       (seg),
        .an        (an),
        .wrap_cnt  (wrap_cnt),
        .wrap_pulse(wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; ecount counts edges since reset was released
    task automatic step();
        @(posedge clk);
        if (rst) ecount = 0;
        else ecount++;
        #1;
    endtask

    function automatic int shown_idx();
        return ((ecount - 1) / 4) % 4;
    endfunction

    function automatic logic [7:0] bcd(input int n);
        return {4'((n % 100) / 10), 4'(n % 10)};
    endfunction

    task automatic do_wrap();
        cnt_in = 4'h0;
        step();
        cnt_in = 4'hF;
        step();
        nwraps++;
        check("wrap_pulse", {7'd0, wrap_pulse}, 8'h01);
        check("wrap_cnt", wrap_cnt, bcd(nwraps));
    endtask

    task automatic clear_wraps();
        cnt_in   = 4'h5;
        wrap_clr = 1'b1;
        step();
        wrap_clr = 1'b0;
        nwraps   = 0;
        check("wrap_clr", wrap_cnt, 8'h00);
    endtask

    logic [3:0] wd_seq   [7];
    logic       wd_pulse [7];
    logic [7:0] wd_cnt   [7];
    logic [3:0] an_exp   [4];
    logic [6:0] seg_exp  [4];

    initial begin
        checks   = 0;
        errors   = 0;
        ecount   = 0;
        nwraps   = 0;
        rst      = 1'b1;
        cnt_in   = 4'h0;
        wrap_clr = 1'b0;

        // Reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_an", {4'd0, an}, 8'h0F);
            check("rst_seg", {1'b0, seg}, 8'h7F);
            check("rst_wrap_cnt", wrap_cnt, 8'h00);
            check("rst_pulse", {7'd0, wrap_pulse}, 8'h00);
        end
        rst = 1'b0;
        step();
        check("rel_an", {4'd0, an}, 8'h0E);
        check("rel_seg", {1'b0, seg}, 8'h40);

        // Wrap detect: 0,F,E,0,1,0,F
        wd_seq   = '{4'h0, 4'hF, 4'hE, 4'h0, 4'h1, 4'h0, 4'hF};
        wd_pulse = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wd_cnt   = '{8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
        for (int i = 0; i < 7; i++) begin
            cnt_in = wd_seq[i];
            step();
            check("wd_pulse", {7'd0, wrap_pulse}, {7'd0, wd_pulse[i]});
            check("wd_wrap_cnt", wrap_cnt, wd_cnt[i]);
        end
        cnt_in = 4'hE;
        step();
        check("wd_pulse_drop", {7'd0, wrap_pulse}, 8'h00);

        // BCD roll over 100 wraps
        clear_wraps();
        for (int i = 0; i < 100; i++) do_wrap();
        check("bcd_final", wrap_cnt, 8'h00);

        // Clear collides with a wrap
        clear_wraps();
        for (int i = 0; i < 42; i++) do_wrap();
        check("coll_pre", wrap_cnt, 8'h42);
        cnt_in = 4'h0;
        step();
        cnt_in   = 4'hF;
        wrap_clr = 1'b1;
        step();
        wrap_clr = 1'b0;
        check("coll_wrap_cnt", wrap_cnt, 8'h00);
        check("coll_pulse", {7'd0, wrap_pulse}, 8'h01);

        // Scan with cnt_in held F and 21 wraps
        clear_wraps();
        for (int i = 0; i < 21; i++) do_wrap();
        step();
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'h0E, 7'h7F, 7'h79, 7'h24};
        for (int i = 0; i < 20; i++) begin
            step();
            check("scan_an", {4'd0, an}, {4'd0, an_exp[shown_idx()]});
            check("scan_seg", {1'b0, seg}, {1'b0, seg_exp[shown_idx()]});
        end

        // Reset mid-scan on digit 2 with a wrap arriving
        clear_wraps();
        for (int i = 0; i < 37; i++) do_wrap();
        check("mid_pre", wrap_cnt, 8'h37);
        cnt_in = 4'h0;
        step();
        for (int i = 0; i < 16 && shown_idx() != 2; i++) step();
        check("mid_idx2_an", {4'd0, an}, 8'h0B);
        rst    = 1'b1;
        cnt_in = 4'hF;
        step();
        check("mid_rst_an", {4'd0, an}, 8'h0F);
        check("mid_rst_seg", {1'b0, seg}, 8'h7F);
        check("mid_rst_wrap_cnt", wrap_cnt, 8'h00);
        check("mid_rst_pulse", {7'd0, wrap_pulse}, 8'h00);
        step();
        rst = 1'b0;
        step();
        check("post_rst_pulse", {7'd0, wrap_pulse}, 8'h00);
        check("post_rst_wrap_cnt", wrap_cnt, 8'h00);
        check("post_rst_an", {4'd0, an}, 8'h0E);
        check("post_rst_seg", {1'b0, seg}, 8'h40);
        step();
        check("post_rst_pulse2", {7'd0, wrap_pulse}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
